// File: rtl/mem_access_stage_pkg.sv
// Shared processor definitions for the memory-access stage: op codes, FSM state encodings,
// and default datapath/destination widths.
package mem_access_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEST_W_DEF = 10;
  localparam int ADDR_W     = 16;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ST      = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_OUT     = 3'd4
  } state_e;

endpackage

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU pass-through, loads (1-cycle read latency) and stores.
// Define STORE_FWD_EN to add a last-store register that serves matching loads without a memory read.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_data2,
  input  logic [DEST_W-1:0] ex_dest,
  output logic [15:0]       mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] wb_write_data2,
  output logic [DEST_W-1:0] wb_write_addr
);

  state_e              state_q, state_d;
  op_e                 acc_op;
  logic [ADDR_W-1:0]   ex_addr;
  logic [DATA_W-1:0]   data2_q, data2_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DATA_W-1:0]   wb_data2_q, wb_data2_d;
  logic [DEST_W-1:0]   wb_addr_q, wb_addr_d;

  assign acc_op  = op_e'(ex_op);
  assign ex_addr = ex_result[ADDR_W-1:0];

`ifdef STORE_FWD_EN
  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic              fwd_hit;

  assign fwd_hit = fwd_valid_q && (fwd_addr_q == ex_addr);

  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    if (state_q == S_IDLE && ex_valid && acc_op == OP_STORE) begin
      fwd_valid_d = 1'b1;
      fwd_addr_d  = ex_addr;
      fwd_data_d  = ex_data2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    data2_d     = data2_q;
    dest_d      = dest_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_data_d   = wb_data_q;
    wb_data2_d  = wb_data2_q;
    wb_addr_d   = wb_addr_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          // NOPs are dropped without touching any register so no output moves.
          if (acc_op != OP_NOP) begin
            data2_d = ex_data2;
            dest_d  = ex_dest;
          end
          unique case (acc_op)
            OP_ALU: begin
              state_d    = S_OUT;
              wb_data_d  = ex_result;
              wb_data2_d = ex_data2;
              wb_addr_d  = ex_dest;
            end
            OP_LOAD: begin
`ifdef STORE_FWD_EN
              if (fwd_hit) begin
                state_d    = S_OUT;
                wb_data_d  = fwd_data_q;
                wb_data2_d = ex_data2;
                wb_addr_d  = ex_dest;
              end else begin
                state_d    = S_RD_ADDR;
                mem_addr_d = ex_addr;
              end
`else
              state_d    = S_RD_ADDR;
              mem_addr_d = ex_addr;
`endif
            end
            OP_STORE: begin
              state_d     = S_ST;
              mem_addr_d  = ex_addr;
              mem_wdata_d = ex_data2;
            end
            default: ;
          endcase
        end
      end
      S_ST:      state_d = S_IDLE;
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: begin
        state_d    = S_OUT;
        wb_data_d  = mem_read_data;
        wb_data2_d = data2_q;
        wb_addr_d  = dest_q;
      end
      S_OUT:     if (wb_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with their state.
  assign mem_re_d   = (state_d == S_RD_ADDR);
  assign mem_we_d   = (state_d == S_ST);
  assign wb_valid_d = (state_d == S_OUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data2_q     <= '0;
      dest_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_data2_q  <= '0;
      wb_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      data2_q     <= data2_d;
      dest_q      <= dest_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_data2_q  <= wb_data2_d;
      wb_addr_q   <= wb_addr_d;
    end
  end

  assign ex_ready       = (state_q == S_IDLE);
  assign mem_addr       = mem_addr_q;
  assign mem_read_en    = mem_re_q;
  assign mem_write_en   = mem_we_q;
  assign mem_write_data = mem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_reg_write   = wb_valid_q;
  assign wb_write_data  = wb_data_q;
  assign wb_write_data2 = wb_data2_q;
  assign wb_write_addr  = wb_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops checked
// against a transaction-level model (memory contents, last store, per-op latencies).
module tb_mem_access_stage;

  localparam int DW = 16;
  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_ready;
  logic [1:0]    ex_op;
  logic [DW-1:0] ex_result, ex_data2;
  logic [TW-1:0] ex_dest;
  logic [15:0]   mem_addr;
  logic          mem_read_en, mem_write_en;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          wb_valid, wb_ready, wb_reg_write;
  logic [DW-1:0] wb_write_data, wb_write_data2;
  logic [TW-1:0] wb_write_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_result(ex_result), .ex_data2(ex_data2), .ex_dest(ex_dest),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg_write(wb_reg_write),
    .wb_write_data(wb_write_data), .wb_write_data2(wb_write_data2),
    .wb_write_addr(wb_write_addr)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A5A;
  endfunction

  // Environment memory: 1-cycle read latency, unwritten words read back as init_val().
  logic [15:0] tb_mem  [0:255];
  bit          tb_wr   [0:255];
  always @(posedge clk) begin
    if (mem_write_en) begin
      tb_mem[mem_addr[7:0]] <= mem_write_data;
      tb_wr[mem_addr[7:0]]  <= 1'b1;
    end
    if (mem_read_en)
      mem_read_data <= tb_wr[mem_addr[7:0]] ? tb_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  // Reference model state.
  logic [15:0] ref_mem [int];
  bit          last_valid = 1'b0;
  logic [15:0] last_addr, last_data;

  typedef struct {
    int          wb_cyc, rd_cyc, wr_cnt, wr_cyc, rw_bad;
    logic [15:0] wb_data, wb_data2, wr_addr, wr_data, rd_addr;
    logic [9:0]  wb_addr;
  } obs_t;

  task automatic model_step(input logic [1:0] op, input logic [15:0] res, d2,
                            input logic [9:0] dest, output obs_t e);
    e = '{wb_cyc: -1, rd_cyc: -1, wr_cnt: 0, wr_cyc: -1, rw_bad: 0,
          wb_data: '0, wb_data2: '0, wr_addr: '0, wr_data: '0, rd_addr: '0, wb_addr: '0};
    case (op)
      2'b00: begin
        e.wb_cyc = 1; e.wb_data = res; e.wb_data2 = d2; e.wb_addr = dest;
      end
      2'b01: begin
        e.wb_data  = ref_mem.exists(int'(res)) ? ref_mem[int'(res)] : init_val(res[7:0]);
        e.wb_data2 = d2; e.wb_addr = dest;
        e.wb_cyc = 3; e.rd_cyc = 1; e.rd_addr = res;
`ifdef STORE_FWD_EN
        if (last_valid && last_addr == res) begin
          e.wb_cyc = 1; e.rd_cyc = -1; e.wb_data = last_data;
        end
`endif
      end
      2'b10: begin
        e.wr_cnt = 1; e.wr_cyc = 1; e.wr_addr = res; e.wr_data = d2;
        ref_mem[int'(res)] = d2;
        last_valid = 1'b1; last_addr = res; last_data = d2;
      end
      default: ;
    endcase
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ex_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout ex_ready=%b expected 1", ex_ready);
    end
  endtask

  task automatic accept(input logic [1:0] op, input logic [15:0] res, d2, input logic [9:0] dest);
    wait_ready();
    ex_valid = 1'b1; ex_op = op; ex_result = res; ex_data2 = d2; ex_dest = dest;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    ex_op = 2'($urandom); ex_result = 16'($urandom); ex_data2 = 16'($urandom); ex_dest = 10'($urandom);
  endtask

  // Issue one op and record what the DUT does over the following six cycles.
  task automatic do_op(input logic [1:0] op, input logic [15:0] res, d2,
                       input logic [9:0] dest, output obs_t o);
    o = '{wb_cyc: -1, rd_cyc: -1, wr_cnt: 0, wr_cyc: -1, rw_bad: 0,
          wb_data: '0, wb_data2: '0, wr_addr: '0, wr_data: '0, rd_addr: '0, wb_addr: '0};
    wb_ready = 1'b1;
    accept(op, res, d2, dest);
    for (int k = 1; k <= 6; k++) begin
      if (wb_reg_write !== wb_valid) o.rw_bad++;
      if (mem_read_en === 1'b1 && o.rd_cyc < 0) begin o.rd_cyc = k; o.rd_addr = mem_addr; end
      if (mem_write_en === 1'b1) begin
        o.wr_cnt++; o.wr_cyc = k; o.wr_addr = mem_addr; o.wr_data = mem_write_data;
      end
      if (wb_valid === 1'b1 && o.wb_cyc < 0) begin
        o.wb_cyc = k; o.wb_data = wb_write_data; o.wb_data2 = wb_write_data2; o.wb_addr = wb_write_addr;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; wb_ready = 1'b1;
    ex_op = 2'b00; ex_result = '0; ex_data2 = '0; ex_dest = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ex_ready, wb_valid, wb_reg_write, mem_read_en, mem_write_en} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=10000", {ex_ready, wb_valid, wb_reg_write, mem_read_en, mem_write_en});
    end
    checks++;
    if ({wb_write_data, wb_write_data2, wb_write_addr, mem_addr, mem_write_data} !== '0) begin
      errors++;
      $display("FAIL reset_data wb_data=%h wb_data2=%h wb_addr=%h mem_addr=%h mem_wdata=%h exp all 0",
               wb_write_data, wb_write_data2, wb_write_addr, mem_addr, mem_write_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    obs_t o, e;
    model_step(2'b00, 16'h1234, 16'h00AA, 10'h045, e);
    do_op(2'b00, 16'h1234, 16'h00AA, 10'h045, o);
    checks++;
    if (o.wb_cyc !== 1) begin errors++; $display("FAIL alu_latency got=%0d exp=1", o.wb_cyc); end
    checks++;
    if (o.wb_data !== 16'h1234 || o.wb_addr !== 10'h045 || o.wb_data2 !== 16'h00AA) begin
      errors++;
      $display("FAIL alu_data got=%h/%h/%h exp=1234/00aa/045", o.wb_data, o.wb_data2, o.wb_addr);
    end
    checks++;
    if (o.rw_bad !== 0) begin errors++; $display("FAIL alu_reg_write bad_cycles=%0d exp=0", o.rw_bad); end
  endtask

  task automatic test_store();
    obs_t o, e;
    model_step(2'b10, 16'h0010, 16'hBEEF, 10'h000, e);
    do_op(2'b10, 16'h0010, 16'hBEEF, 10'h000, o);
    checks++;
    if (o.wr_cnt !== 1 || o.wr_cyc !== 1) begin
      errors++; $display("FAIL store_strobe count=%0d cycle=%0d exp=1/1", o.wr_cnt, o.wr_cyc);
    end
    checks++;
    if (o.wr_addr !== 16'h0010 || o.wr_data !== 16'hBEEF) begin
      errors++; $display("FAIL store_data addr=%h data=%h exp=0010/beef", o.wr_addr, o.wr_data);
    end
    checks++;
    if (o.wb_cyc !== -1) begin errors++; $display("FAIL store_wb_valid cycle=%0d exp=none", o.wb_cyc); end
  endtask

  task automatic test_load();
    obs_t o, e;
    model_step(2'b01, 16'h0010, 16'h1111, 10'h123, e);
    do_op(2'b01, 16'h0010, 16'h1111, 10'h123, o);
    checks++;
    if (o.wb_cyc !== e.wb_cyc) begin errors++; $display("FAIL load_latency got=%0d exp=%0d", o.wb_cyc, e.wb_cyc); end
    checks++;
    if (o.rd_cyc !== e.rd_cyc) begin errors++; $display("FAIL load_read_en cycle=%0d exp=%0d", o.rd_cyc, e.rd_cyc); end
    checks++;
    if (o.wb_data !== 16'hBEEF || o.wb_addr !== 10'h123 || o.wb_data2 !== 16'h1111) begin
      errors++;
      $display("FAIL load_data got=%h/%h/%h exp=beef/1111/123", o.wb_data, o.wb_data2, o.wb_addr);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] res, d2;
    logic [9:0]  dest;
    res = 16'($urandom); d2 = 16'($urandom); dest = 10'($urandom);
    wb_ready = 1'b0;
    accept(2'b00, res, d2, dest);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || ex_ready !== 1'b0 ||
          wb_write_data !== res || wb_write_data2 !== d2 || wb_write_addr !== dest) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b rw=%b ex_ready=%b data=%h/%h addr=%h exp 1/1/0 %h/%h %h",
                 k, wb_valid, wb_reg_write, ex_ready, wb_write_data, wb_write_data2, wb_write_addr, res, d2, dest);
      end
      // Junk offered while busy must be ignored.
      ex_valid = (k < 4); ex_op = 2'b00; ex_result = 16'($urandom); ex_dest = 10'($urandom);
      if (k == 4) wb_ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release ex_ready=%b wb_valid=%b exp 1/0", ex_ready, wb_valid);
    end
  endtask

  task automatic test_reset_abort();
    for (int pass = 0; pass < 2; pass++) begin
      int bad = 0;
      logic [15:0] d2;
      d2 = 16'($urandom);
      if (pass == 0) begin
        accept(2'b01, 16'h0005, d2, 10'h011);
        @(posedge clk); #1;                       // now in RD_DATA
      end else begin
        accept(2'b10, 16'h0007, d2, 10'h000);     // now in ST, write already committing
        ref_mem[7] = d2;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_valid = 1'b0;
      checks++;
      if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || wb_reg_write !== 1'b0 ||
          {wb_write_data, wb_write_data2, wb_write_addr, mem_addr, mem_write_data} !== '0) begin
        errors++;
        $display("FAIL abort_state pass=%0d ex_ready=%b valid=%b rw=%b data=%h/%h addr=%h mem=%h/%h exp 1/0/0 all 0",
                 pass, ex_ready, wb_valid, wb_reg_write, wb_write_data, wb_write_data2,
                 wb_write_addr, mem_addr, mem_write_data);
      end
      for (int k = 0; k < 4; k++) begin
        if (wb_valid !== 1'b0 || mem_write_en !== 1'b0 || mem_read_en !== 1'b0) bad++;
        @(posedge clk); #1;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL abort_quiet pass=%0d active_cycles=%0d exp=0", pass, bad); end
    end
  endtask

  task automatic test_nop();
    obs_t o, e;
    model_step(2'b11, 16'hFFFF, 16'hFFFF, 10'h3FF, e);
    do_op(2'b11, 16'hFFFF, 16'hFFFF, 10'h3FF, o);
    checks++;
    if (o.wb_cyc !== -1 || o.rd_cyc !== -1 || o.wr_cnt !== 0) begin
      errors++; $display("FAIL nop_activity wb=%0d rd=%0d wr=%0d exp none", o.wb_cyc, o.rd_cyc, o.wr_cnt);
    end
    checks++;
    if ({wb_write_data, wb_write_data2, wb_write_addr, mem_addr, mem_write_data} !== '0) begin
      errors++;
      $display("FAIL nop_outputs data=%h/%h addr=%h mem=%h/%h exp all 0",
               wb_write_data, wb_write_data2, wb_write_addr, mem_addr, mem_write_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      obs_t o, e;
      logic [1:0]  op;
      logic [15:0] res, d2;
      logic [9:0]  dest;
      op   = 2'($urandom);
      res  = (op == 2'b00) ? 16'($urandom) : 16'($urandom_range(0, 15));
      d2   = 16'($urandom);
      dest = 10'($urandom);
      model_step(op, res, d2, dest, e);
      do_op(op, res, d2, dest, o);
      checks++;
      if (o.wb_cyc !== e.wb_cyc || o.rd_cyc !== e.rd_cyc || o.wr_cnt !== e.wr_cnt || o.rw_bad !== 0) begin
        errors++;
        $display("FAIL rand%0d_timing op=%0d wb=%0d rd=%0d wr=%0d rwbad=%0d exp wb=%0d rd=%0d wr=%0d rwbad=0",
                 i, op, o.wb_cyc, o.rd_cyc, o.wr_cnt, o.rw_bad, e.wb_cyc, e.rd_cyc, e.wr_cnt);
      end
      if (e.wb_cyc > 0) begin
        checks++;
        if (o.wb_data !== e.wb_data || o.wb_data2 !== e.wb_data2 || o.wb_addr !== e.wb_addr) begin
          errors++;
          $display("FAIL rand%0d_wb op=%0d got=%h/%h/%h exp=%h/%h/%h", i, op,
                   o.wb_data, o.wb_data2, o.wb_addr, e.wb_data, e.wb_data2, e.wb_addr);
        end
      end
      if (e.rd_cyc > 0) begin
        checks++;
        if (o.rd_addr !== e.rd_addr) begin
          errors++; $display("FAIL rand%0d_rd_addr got=%h exp=%h", i, o.rd_addr, e.rd_addr);
        end
      end
      if (e.wr_cnt > 0) begin
        checks++;
        if (o.wr_cyc !== e.wr_cyc || o.wr_addr !== e.wr_addr || o.wr_data !== e.wr_data) begin
          errors++;
          $display("FAIL rand%0d_store cyc=%0d addr=%h data=%h exp cyc=%0d addr=%h data=%h",
                   i, o.wr_cyc, o.wr_addr, o.wr_data, e.wr_cyc, e.wr_addr, e.wr_data);
        end
      end
      $display("txn %0d op=%0d res=%h d2=%h dest=%h wb_cyc=%0d wb_data=%h", i, op, res, d2, dest, o.wb_cyc, o.wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_backpressure();
    test_reset_abort();
    test_nop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath width.
REQ-002 SHALL have parameter DEST_W, default 10: packed destination field width, two 5-bit register indices {dest2,dest1}.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have ports ex_valid in 1, ex_ready out 1, ex_op in 2, ex_result in DATA_W, ex_data2 in DATA_W, ex_dest in DEST_W: execute-side handshake, op, ALU result/address, second result/store data, destinations.
REQ-006 SHALL have ports mem_addr out 16, mem_read_en out 1, mem_write_en out 1, mem_write_data out DATA_W, mem_read_data in DATA_W: data-memory port with 1-cycle read latency.
REQ-007 SHALL have ports wb_valid out 1, wb_ready in 1, wb_reg_write out 1, wb_write_data out DATA_W, wb_write_data2 out DATA_W, wb_write_addr out DEST_W: outputs to the write-back stage.

Function
REQ-008 SHALL decode ex_op as 00 ALU, 01 LOAD, 10 STORE, 11 NOP.
REQ-009 SHALL implement FSM states IDLE, ST, RD_ADDR, RD_DATA, OUT; ex_ready = 1 only in IDLE.
REQ-010 SHALL, in IDLE on ex_valid&&ex_ready, latch ex_op/ex_result/ex_data2/ex_dest and go: ALU->OUT, LOAD->RD_ADDR, STORE->ST, NOP->IDLE (discarded, no side effect).
REQ-011 SHALL, in ST, drive mem_write_en=1, mem_addr=latched ex_result[15:0], mem_write_data=latched ex_data2 for exactly one cycle, then return to IDLE; stores SHALL NOT raise wb_valid.
REQ-012 SHALL, in RD_ADDR, drive mem_read_en=1 and mem_addr=latched address for one cycle, then go to RD_DATA.
REQ-013 SHALL, in RD_DATA, capture mem_read_data into the wb_write_data register, then go to OUT.
REQ-014 SHALL, in OUT, assert wb_valid=1 and wb_reg_write=1, wb_write_data = ALU result (ALU) or loaded data (LOAD), wb_write_data2 = latched ex_data2, wb_write_addr = latched ex_dest.
REQ-015 SHALL hold all wb_* outputs stable while wb_valid=1 and wb_ready=0; on wb_ready=1 go to IDLE the next cycle.
REQ-016 SHALL give latencies from accept edge to wb_valid: ALU 1 cycle, LOAD 3 cycles; STORE write occurs the cycle after accept.
REQ-017 SHALL drive mem_read_en=0, mem_write_en=0 in every state other than RD_ADDR and ST respectively; wb_reg_write=0 whenever wb_valid=0.
REQ-018 SHALL ignore ex_valid and all ex_* inputs while ex_ready=0.

Reset
REQ-019 SHALL, when rst_n=0 at a rising edge, enter IDLE and clear wb_valid, wb_reg_write, wb_write_data, wb_write_data2, wb_write_addr, mem_addr and mem_write_data to 0.
REQ-020 SHALL abort any in-flight op on reset: no mem_write_en and no wb_valid after the reset edge until a new accept.

Configuration
REQ-021 SHALL, with STORE_FWD_EN defined, keep a last-store register (address, data, valid, valid cleared by reset); a LOAD whose address equals a valid last-store address SHALL go IDLE->OUT with the stored data, latency 1, mem_read_en never asserted.
REQ-022 SHALL, without STORE_FWD_EN, contain no forwarding logic; every LOAD takes the RD_ADDR/RD_DATA path.

Structure
REQ-023 SHALL take op encodings, FSM state encodings and DATA_W/DEST_W defaults from the shared processor package.
REQ-024 SHALL be a single module; the optional store-forward register MAY be sub-module store_fwd_buf.

Verification
REQ-025 ALU op, ex_result=16'h1234, ex_dest=10'h045 accepted -> next cycle wb_valid=1, wb_reg_write=1, wb_write_data=16'h1234, wb_write_addr=10'h045.
REQ-026 STORE addr 16'h0010, data 16'hBEEF -> next cycle one-cycle mem_write_en=1 at addr 16'h0010, data 16'hBEEF; wb_valid stays 0.
REQ-027 LOAD addr 16'h0010, memory returns 16'hBEEF -> mem_read_en 1 cycle after accept, wb_valid=1 with wb_write_data=16'hBEEF 3 cycles after accept (with STORE_FWD_EN after scenario REQ-026: 1 cycle, no mem_read_en).
REQ-028 ALU result ready with wb_ready=0 for 4 cycles -> wb_* stable, ex_ready=0 throughout; wb_ready=1 -> IDLE next cycle, ex_ready=1.
REQ-029 rst_n=0 in RD_DATA and in ST -> IDLE, wb_valid=0, no mem_write_en, all wb_* outputs 0; NOP accepted -> no outputs change.
